// File: rtl/fios_ctrl_pkg.sv
// Shared constants and types for the FIOS processing-element sequencer.
// Holds the DSP OPMODE encodings, the FSM state type and the per-step opcode rule.
package fios_ctrl_pkg;

    localparam logic [6:0] OP_IDLE = 7'b0000000;
    localparam logic [6:0] OP_MC   = 7'b0110101;
    localparam logic [6:0] OP_MPS  = 7'b1100101;
    localparam logic [6:0] OP_PS   = 7'b1100000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // j=0 loads M+C, the final j=S step only flushes the carry out of P
    function automatic logic [6:0] opmode_for_step(input int unsigned j, input int unsigned s);
        if (j == 0)
            return OP_MC;
        else if (j >= s)
            return OP_PS;
        else
            return OP_MPS;
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register with synchronous clear, used to align control
// signals with the DSP register levels. DEPTH=0 degenerates to a wire.
module ctrl_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_inputs;
            assign unused_inputs = clk ^ clr;
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (clr) begin
                    for (int unsigned k = 0; k < DEPTH; k++)
                        stage_q[k] <= '0;
                end else begin
                    stage_q[0] <= d;
                    for (int unsigned k = 1; k < DEPTH; k++)
                        stage_q[k] <= stage_q[k-1];
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fios_casc_3a_ctrl.sv
// Sequencer for one FIOS processing element on the cascaded 17x17 DSP48E1 wrapper:
// walks (i,j), issues operand reads, aligns OPMODE/CEC and result write strobes.
module fios_casc_3a_ctrl
    import fios_ctrl_pkg::*;
#(
    parameter  int unsigned WORD_COUNT    = 8,
    parameter  int unsigned ABREG         = 1,
    parameter  int unsigned MREG          = 1,
    localparam int unsigned DSP_REG_LEVEL = 1 + ABREG + MREG,
    localparam int unsigned ADDR_W        = $clog2(WORD_COUNT + 1)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] a_addr_o,
    output logic [ADDR_W-1:0] b_addr_o,
    output logic [6:0]        OPMODE_o,
    output logic              CREG_en_o,
    output logic              res_we_o,
    output logic [ADDR_W-1:0] res_addr_o
);

    localparam int unsigned       OP_DEPTH = ABREG + MREG;
    localparam int unsigned       WR_DEPTH = DSP_REG_LEVEL + 1;
    localparam logic [ADDR_W-1:0] J_LAST   = ADDR_W'(WORD_COUNT);
    localparam logic [ADDR_W-1:0] I_LAST   = ADDR_W'(WORD_COUNT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] i_q, j_q;
    logic [2:0]        drain_q;
    logic              issuing, last_step;
    logic [6:0]        step_op;
    logic              step_creg;
    logic [7:0]        op_dly;
    logic [ADDR_W:0]   wr_dly;

    assign issuing   = (state_q == ISSUE);
    assign last_step = issuing && (i_q == I_LAST) && (j_q == J_LAST);

    always_ff @(posedge clock_i) begin
        if (reset_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = ISSUE;
            ISSUE:   if (last_step) state_d = DRAIN;
            DRAIN:   if (drain_q == '0) state_d = DONE;
            DONE:    state_d = start_i ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Drain length equals the write-path depth, i.e. until the last write has left the line
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            i_q     <= '0;
            j_q     <= '0;
            drain_q <= '0;
        end else begin
            if (issuing) begin
                if (j_q == J_LAST) begin
                    j_q <= '0;
                    i_q <= last_step ? '0 : i_q + ADDR_W'(1);
                end else begin
                    j_q <= j_q + ADDR_W'(1);
                end
            end
            if (last_step)
                drain_q <= 3'(WR_DEPTH - 1);
            else if (state_q == DRAIN && drain_q != '0)
                drain_q <= drain_q - 3'd1;
        end
    end

    always_comb begin
        step_op   = OP_IDLE;
        step_creg = 1'b0;
        if (issuing) begin
            step_op   = opmode_for_step(32'(j_q), WORD_COUNT);
            step_creg = (j_q == '0);
        end
    end

    ctrl_delay_line #(.WIDTH(8), .DEPTH(OP_DEPTH)) u_op_dly (
        .clk (clock_i),
        .clr (reset_i),
        .d   ({step_op, step_creg}),
        .q   (op_dly)
    );

    ctrl_delay_line #(.WIDTH(ADDR_W + 1), .DEPTH(WR_DEPTH)) u_wr_dly (
        .clk (clock_i),
        .clr (reset_i),
        .d   ({issuing, j_q}),
        .q   (wr_dly)
    );

    assign {OPMODE_o, CREG_en_o}  = op_dly;
    assign {res_we_o, res_addr_o} = wr_dly;

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);
    assign rd_en_o  = issuing;
    assign a_addr_o = i_q;
    assign b_addr_o = j_q;

endmodule

// File: tb/tb_fios_casc_3a_ctrl.sv
// Self-checking bench for fios_casc_3a_ctrl: cycle-exact schedule model plus a
// behavioural DSP/big-integer reference for the S=4 data path.
module tb_fios_casc_3a_ctrl;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd_en;
        logic [6:0] a;
        logic [6:0] b;
        logic [6:0] op;
        logic       creg;
        logic       we;
        logic [6:0] addr;
    } outs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start2 = 1'b0, start0 = 1'b0, start4 = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // S=2, ABREG=MREG=1
    logic       busy2, done2, rd2, creg2, we2;
    logic [1:0] a2, b2, addr2;
    logic [6:0] op2;
    // S=2, ABREG=MREG=0
    logic       busy0, done0, rd0, creg0, we0;
    logic [1:0] a0, b0, addr0;
    logic [6:0] op0;
    // S=4, ABREG=MREG=1
    logic       busy4, done4, rd4, creg4, we4;
    logic [2:0] a4, b4, addr4;
    logic [6:0] op4;

    fios_casc_3a_ctrl #(.WORD_COUNT(2), .ABREG(1), .MREG(1)) dut2 (
        .clock_i(clk), .reset_i(rst), .start_i(start2), .busy_o(busy2), .done_o(done2),
        .rd_en_o(rd2), .a_addr_o(a2), .b_addr_o(b2), .OPMODE_o(op2), .CREG_en_o(creg2),
        .res_we_o(we2), .res_addr_o(addr2)
    );

    fios_casc_3a_ctrl #(.WORD_COUNT(2), .ABREG(0), .MREG(0)) dut0 (
        .clock_i(clk), .reset_i(rst), .start_i(start0), .busy_o(busy0), .done_o(done0),
        .rd_en_o(rd0), .a_addr_o(a0), .b_addr_o(b0), .OPMODE_o(op0), .CREG_en_o(creg0),
        .res_we_o(we0), .res_addr_o(addr0)
    );

    fios_casc_3a_ctrl #(.WORD_COUNT(4), .ABREG(1), .MREG(1)) dut4 (
        .clock_i(clk), .reset_i(rst), .start_i(start4), .busy_o(busy4), .done_o(done4),
        .rd_en_o(rd4), .a_addr_o(a4), .b_addr_o(b4), .OPMODE_o(op4), .CREG_en_o(creg4),
        .res_we_o(we4), .res_addr_o(addr4)
    );

    // Addresses are only meaningful while their strobe is high
    outs_t obs2, obs0, obs4;
    always_comb begin
        obs2 = '0;
        obs2.busy = busy2; obs2.done = done2; obs2.rd_en = rd2;
        obs2.a = rd2 ? 7'(a2) : 7'd0;  obs2.b = rd2 ? 7'(b2) : 7'd0;
        obs2.op = op2; obs2.creg = creg2; obs2.we = we2;
        obs2.addr = we2 ? 7'(addr2) : 7'd0;
        obs0 = '0;
        obs0.busy = busy0; obs0.done = done0; obs0.rd_en = rd0;
        obs0.a = rd0 ? 7'(a0) : 7'd0;  obs0.b = rd0 ? 7'(b0) : 7'd0;
        obs0.op = op0; obs0.creg = creg0; obs0.we = we0;
        obs0.addr = we0 ? 7'(addr0) : 7'd0;
        obs4 = '0;
        obs4.busy = busy4; obs4.done = done4; obs4.rd_en = rd4;
        obs4.a = rd4 ? 7'(a4) : 7'd0;  obs4.b = rd4 ? 7'(b4) : 7'd0;
        obs4.op = op4; obs4.creg = creg4; obs4.we = we4;
        obs4.addr = we4 ? 7'(addr4) : 7'd0;
    end

    // Expected outputs r cycles after the first issue cycle, for S words and l=ABREG+MREG
    function automatic outs_t model(int r, int s, int l);
        outs_t e;
        int n, k;
        e = '0;
        n = s * (s + 1);
        if (r >= 0 && r <= n + l + 2) e.busy = 1'b1;
        if (r == n + l + 2) e.done = 1'b1;
        if (r >= 0 && r < n) begin
            e.rd_en = 1'b1;
            e.a = 7'(r / (s + 1));
            e.b = 7'(r % (s + 1));
        end
        k = r - l;
        if (k >= 0 && k < n) begin
            if (k % (s + 1) == 0) begin
                e.op = 7'h35;
                e.creg = 1'b1;
            end else if (k % (s + 1) == s) begin
                e.op = 7'h60;
            end else begin
                e.op = 7'h65;
            end
        end
        k = r - l - 2;
        if (k >= 0 && k < n) begin
            e.we = 1'b1;
            e.addr = 7'(k % (s + 1));
        end
        return e;
    endfunction

    // Operand memories (1-cycle read) and a DSP with AREG/BREG, MREG, OPMODEREG, CREG
    logic [16:0] mem_a [8];
    logic [16:0] mem_b [8];
    logic [16:0] c_in;
    logic [16:0] rda, rdb, areg, breg;
    logic [47:0] mreg, creg_q, p_q;
    logic [6:0]  opreg;

    always @(posedge clk) begin
        if (rd4) begin
            rda <= mem_a[a4];
            rdb <= mem_b[b4];
        end
        areg  <= rda;
        breg  <= rdb;
        mreg  <= 48'(areg) * 48'(breg);
        opreg <= op4;
        if (creg4) creg_q <= 48'(c_in);
        case (opreg)
            7'h35:   p_q <= mreg + creg_q;
            7'h65:   p_q <= mreg + (p_q >> 17);
            7'h60:   p_q <= p_q >> 17;
            default: p_q <= p_q;
        endcase
    end

    // Row i of the result is the 17-bit word split of a_i * B + C
    function automatic logic [16:0] exp_word(int i, int j);
        logic [127:0] bigb, v;
        bigb = '0;
        for (int k = 0; k < 4; k++)
            bigb = bigb | (128'(mem_b[k]) << (17 * k));
        v = 128'(mem_a[i]) * bigb + 128'(c_in);
        return 17'(v >> (17 * j));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (obs2 !== '0) begin
            miscompares++;
            $display("FAIL reset_s2 got=%h exp=%h", obs2, outs_t'('0));
        end
        vectors++;
        if (obs0 !== '0) begin
            miscompares++;
            $display("FAIL reset_noreg got=%h exp=%h", obs0, outs_t'('0));
        end
        vectors++;
        if (obs4 !== '0 || a4 !== 3'd0 || b4 !== 3'd0 || addr4 !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_s4 got=%h a=%0d b=%0d addr=%0d exp=all zero", obs4, a4, b4, addr4);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequence_s2();
        outs_t e;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            start2 = 1'b0;
            e = model(r, 2, 2);
            vectors++;
            if (obs2 !== e) begin
                miscompares++;
                $display("FAIL seq_s2 r=%0d got=%h exp=%h", r, obs2, e);
            end
        end
    endtask

    task automatic test_no_regs();
        outs_t e;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            start0 = 1'b0;
            e = model(r, 2, 0);
            vectors++;
            if (obs0 !== e) begin
                miscompares++;
                $display("FAIL noreg r=%0d got=%h exp=%h", r, obs0, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        outs_t e;
        int p;
        p = 6 + 2 + 3;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        for (int r = 0; r < 2 * p + 3; r++) begin
            @(negedge clk);
            e = (r < p) ? model(r, 2, 2) : model(r - p, 2, 2);
            vectors++;
            if (obs2 !== e) begin
                miscompares++;
                $display("FAIL back_to_back r=%0d got=%h exp=%h", r, obs2, e);
            end
            if (r <= p - 1)
                start2 = 1'b1;
            else if (r <= p + 9)
                start2 = 1'($urandom % 2);
            else
                start2 = 1'b0;
        end
        start2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        outs_t e;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            start2 = 1'b0;
            e = model(r, 2, 2);
            vectors++;
            if (obs2 !== e) begin
                miscompares++;
                $display("FAIL reset_mid_pre r=%0d got=%h exp=%h", r, obs2, e);
            end
        end
        rst = 1'b1;
        for (int r = 4; r < 13; r++) begin
            @(negedge clk);
            rst = 1'b0;
            vectors++;
            if (obs2 !== '0) begin
                miscompares++;
                $display("FAIL reset_mid_post r=%0d got=%h exp=%h", r, obs2, outs_t'('0));
            end
        end
        start2 = 1'b1;
        @(posedge clk);
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            start2 = 1'b0;
            e = model(r, 2, 2);
            vectors++;
            if (obs2 !== e) begin
                miscompares++;
                $display("FAIL reset_mid_rerun r=%0d got=%h exp=%h", r, obs2, e);
            end
        end
    endtask

    task automatic test_dsp_model();
        int  writes;
        bit  got_done;
        logic [16:0] w;
        for (int op = 0; op < 1000; op++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                mem_a[k] = 17'($urandom);
                mem_b[k] = 17'($urandom);
            end
            c_in = 17'($urandom);
            start4 = 1'b1;
            @(posedge clk);
            writes = 0;
            got_done = 1'b0;
            for (int c = 0; c < 60 && !got_done; c++) begin
                @(negedge clk);
                start4 = 1'b0;
                if (we4) begin
                    w = exp_word(writes / 5, writes % 5);
                    vectors++;
                    if (addr4 !== 3'(writes % 5) || p_q[16:0] !== w) begin
                        miscompares++;
                        $display("FAIL dsp_word op=%0d n=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                                 op, writes, addr4, p_q[16:0], writes % 5, w);
                    end
                    writes++;
                end
                if (done4) got_done = 1'b1;
            end
            vectors++;
            if (!got_done || writes != 20) begin
                miscompares++;
                $display("FAIL dsp_count op=%0d got done=%0d writes=%0d exp done=1 writes=20",
                         op, got_done, writes);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence_s2();
        test_no_regs();
        test_back_to_back();
        test_reset_mid();
        test_dsp_model();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
